// File: rtl/regfile_write_queue_pkg.sv
// Shared widths and the write-request record for the regfile write queue.
// Both producers and the queue storage use this record.
package regfile_write_queue_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_write_queue_if.sv
// Producer handshakes, regfile write port and read-index snoop/forward bundle.
// The queue uses the slave modport; producers and the regfile side use the master modport.
interface regfile_write_queue_if
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                     a_valid;
    logic                     a_ready;
    logic [ADDR_W-1:0]        a_reg;
    logic [DATA_W-1:0]        a_data;
    logic                     b_valid;
    logic                     b_ready;
    logic [ADDR_W-1:0]        b_reg;
    logic [DATA_W-1:0]        b_data;
    logic                     ctrl_writeEnable;
    logic [ADDR_W-1:0]        ctrl_writeReg;
    logic [DATA_W-1:0]        data_writeReg;
    logic [ADDR_W-1:0]        ctrl_readRegA;
    logic [ADDR_W-1:0]        ctrl_readRegB;
    logic                     fwd_hitA;
    logic [DATA_W-1:0]        fwd_dataA;
    logic                     fwd_hitB;
    logic [DATA_W-1:0]        fwd_dataB;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  ctrl_readRegA, ctrl_readRegB,
        output a_ready, b_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output fwd_hitA, fwd_dataA, fwd_hitB, fwd_dataB, count
    );

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output ctrl_readRegA, ctrl_readRegB,
        input  a_ready, b_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  fwd_hitA, fwd_dataA, fwd_hitB, fwd_dataB, count
    );

endinterface

// File: rtl/regfile_write_queue_wq_match.sv
// Youngest-match search over the occupied entries of a circular buffer.
// Entries are walked oldest to youngest, so the last match wins.
module wq_match
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic [DEPTH-1:0][ADDR_W-1:0] tags,
    input  logic [DEPTH-1:0][DATA_W-1:0] datas,
    input  logic [$clog2(DEPTH)-1:0]     head,
    input  logic [$clog2(DEPTH):0]       count,
    input  logic [ADDR_W-1:0]            key,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count) && (key != ZERO_REG) && (tags[idx] == key)) begin
                hit  = 1'b1;
                data = datas[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// Two-producer write queue draining one entry per cycle into the regfile write port,
// with read-side forwarding of still-pending writes.
module regfile_write_queue
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                 clock,
    input  logic                 ctrl_reset,
    regfile_write_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wr_req_t                     mem_q [DEPTH];
    logic [PW-1:0]               head_q, head_d, tail_q, tail_d, b_slot;
    logic [CW-1:0]               count_q, count_d, free;
    logic                        a_push, b_push, pop, write_en;
    logic [DEPTH-1:0][ADDR_W-1:0] tags;
    logic [DEPTH-1:0][DATA_W-1:0] datas;
    logic                        hit_a, hit_b;
    logic [DATA_W-1:0]           data_a, data_b;

    // Ready uses the registered count only; a same-cycle pop gives no extra credit.
    always_comb begin
        free        = CW'(DEPTH) - count_q;
        bus.a_ready = !ctrl_reset && (free >= CW'(1));
        bus.b_ready = !ctrl_reset && ((free >= CW'(2)) || ((free >= CW'(1)) && !bus.a_valid));
        a_push      = bus.a_valid && bus.a_ready && (bus.a_reg != ZERO_REG);
        b_push      = bus.b_valid && bus.b_ready && (bus.b_reg != ZERO_REG);
        pop         = (count_q != '0);
        b_slot      = a_push ? tail_q + PW'(1) : tail_q;
        tail_d      = tail_q + PW'(a_push) + PW'(b_push);
        head_d      = head_q + PW'(pop);
        count_d     = count_q - CW'(pop) + CW'(a_push) + CW'(b_push);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (ctrl_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage is not reset; count alone says which entries are valid.
    always_ff @(posedge clock) begin
        if (a_push) mem_q[tail_q] <= wr_req_t'{idx: bus.a_reg, data: bus.a_data};
        if (b_push) mem_q[b_slot] <= wr_req_t'{idx: bus.b_reg, data: bus.b_data};
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            tags[k]  = mem_q[k].idx;
            datas[k] = mem_q[k].data;
        end
    end

    // Reset forces the write port low, so a head presented at a reset edge is never written.
    assign write_en             = !ctrl_reset && pop;
    assign bus.ctrl_writeEnable = write_en;
    assign bus.ctrl_writeReg    = write_en ? mem_q[head_q].idx  : '0;
    assign bus.data_writeReg    = write_en ? mem_q[head_q].data : '0;
    assign bus.count            = count_q;

    wq_match #(.DEPTH(DEPTH)) u_match_a (
        .tags  (tags),
        .datas (datas),
        .head  (head_q),
        .count (count_q),
        .key   (bus.ctrl_readRegA),
        .hit   (hit_a),
        .data  (data_a)
    );

    wq_match #(.DEPTH(DEPTH)) u_match_b (
        .tags  (tags),
        .datas (datas),
        .head  (head_q),
        .count (count_q),
        .key   (bus.ctrl_readRegB),
        .hit   (hit_b),
        .data  (data_b)
    );

    assign bus.fwd_hitA  = !ctrl_reset && hit_a;
    assign bus.fwd_dataA = (!ctrl_reset && hit_a) ? data_a : '0;
    assign bus.fwd_hitB  = !ctrl_reset && hit_b;
    assign bus.fwd_dataB = (!ctrl_reset && hit_b) ? data_b : '0;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed plus randomized bench for regfile_write_queue against a queue-based reference model.
// Every cycle all outputs are compared with the model before the rising edge.
module tb_regfile_write_queue;
    import regfile_write_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic ctrl_reset;
    always #5 clock = ~clock;

    regfile_write_queue_if #(.DEPTH(DEPTH)) bus ();

    regfile_write_queue #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    wr_req_t mq [$];
    int      n_tests = 0;
    int      n_fail  = 0;
    logic    last_a_acc, last_b_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Youngest pending write to key, taken straight from the ordered model queue.
    function automatic void fwd_ref(input logic [ADDR_W-1:0] key, output logic hit,
                                    output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (!ctrl_reset && key != 0)
            foreach (mq[i]) if (mq[i].idx == key) begin
                hit = 1'b1;
                d   = mq[i].data;
            end
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        int free;
        logic ar, br, we, eh;
        logic [DATA_W-1:0] ed;
        #1;
        free = DEPTH - mq.size();
        ar = !ctrl_reset && free >= 1;
        br = !ctrl_reset && (free >= 2 || (free >= 1 && !bus.a_valid));
        we = !ctrl_reset && mq.size() != 0;
        check("a_ready", bus.a_ready, ar);
        check("b_ready", bus.b_ready, br);
        check("count", bus.count, mq.size());
        check("write_en", bus.ctrl_writeEnable, we);
        check("write_reg", bus.ctrl_writeReg, we ? mq[0].idx : '0);
        check("write_data", bus.data_writeReg, we ? mq[0].data : '0);
        fwd_ref(bus.ctrl_readRegA, eh, ed);
        check("fwd_hitA", bus.fwd_hitA, eh);
        check("fwd_dataA", bus.fwd_dataA, ed);
        fwd_ref(bus.ctrl_readRegB, eh, ed);
        check("fwd_hitB", bus.fwd_hitB, eh);
        check("fwd_dataB", bus.fwd_dataB, ed);
        last_a_acc = bus.a_valid && ar;
        last_b_acc = bus.b_valid && br;
        @(posedge clock);
        if (ctrl_reset) mq.delete();
        else begin
            if (mq.size() != 0) void'(mq.pop_front());
            if (last_a_acc && bus.a_reg != 0) mq.push_back(wr_req_t'{idx: bus.a_reg, data: bus.a_data});
            if (last_b_acc && bus.b_reg != 0) mq.push_back(wr_req_t'{idx: bus.b_reg, data: bus.b_data});
        end
        @(negedge clock);
    endtask

    task automatic set_a(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        bus.a_valid = v; bus.a_reg = r; bus.a_data = d;
    endtask

    task automatic set_b(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        bus.b_valid = v; bus.b_reg = r; bus.b_data = d;
    endtask

    task automatic drain();
        set_a(0, 0, 0);
        set_b(0, 0, 0);
        for (int i = 0; i < 20 && mq.size() != 0; i++) cycle();
        check("drain_empty", bus.count, 0);
    endtask

    initial begin
        ctrl_reset = 1'b1;
        set_a(0, 0, 0);
        set_b(0, 0, 0);
        bus.ctrl_readRegA = '0;
        bus.ctrl_readRegB = '0;
        @(negedge clock);
        cycle();
        ctrl_reset = 1'b0;
        check("reset_count", bus.count, 0);
        check("reset_we", bus.ctrl_writeEnable, 0);

        // Single write lands on the write port one cycle after acceptance.
        set_a(1, 3, 32'hDEADBEEF);
        cycle();
        set_a(0, 0, 0);
        check("single_we", bus.ctrl_writeEnable, 1);
        check("single_reg", bus.ctrl_writeReg, 3);
        check("single_data", bus.data_writeReg, 32'hDEADBEEF);
        cycle();
        check("single_count", bus.count, 0);

        // Dual enqueue to the same register: A older than B, B forwarded.
        set_a(1, 5, 32'h11);
        set_b(1, 5, 32'h22);
        bus.ctrl_readRegA = 5;
        cycle();
        set_a(0, 0, 0);
        set_b(0, 0, 0);
        check("dual_data0", bus.data_writeReg, 32'h11);
        check("dual_fwd0", bus.fwd_dataA, 32'h22);
        cycle();
        check("dual_data1", bus.data_writeReg, 32'h22);
        check("dual_fwd1", bus.fwd_dataA, 32'h22);
        cycle();
        check("dual_fwd_gone", bus.fwd_hitA, 0);

        // Fill with A to regs 1..4 while B (reg 6) waits for room.
        set_b(1, 6, 32'h66);
        for (int i = 1; i <= 4; i++) begin
            set_a(1, ADDR_W'(i), DATA_W'(i * 16));
            last_a_acc = 1'b0;
            for (int t = 0; t < 10; t++) begin
                cycle();
                if (last_b_acc) set_b(0, 0, 0);
                if (last_a_acc) break;
            end
            check("fill_a_accepted", last_a_acc, 1);
        end
        set_a(0, 0, 0);
        for (int t = 0; t < 10 && bus.b_valid; t++) begin
            cycle();
            if (last_b_acc) set_b(0, 0, 0);
        end
        check("fill_b_accepted", bus.b_valid, 0);
        drain();

        // Register 0 is accepted but dropped.
        set_a(1, 0, 32'hFFFF);
        bus.ctrl_readRegA = 0;
        cycle();
        set_a(0, 0, 0);
        check("r0_count", bus.count, 0);
        check("r0_we", bus.ctrl_writeEnable, 0);
        check("r0_hit", bus.fwd_hitA, 0);

        // Reset with three pending entries.
        set_a(1, 7, 32'h77);  set_b(1, 8, 32'h88);  cycle();
        set_a(1, 9, 32'h99);  set_b(0, 0, 0);       cycle();
        set_a(1, 10, 32'hAA); set_b(1, 11, 32'hBB); cycle();
        set_a(0, 0, 0);
        set_b(0, 0, 0);
        check("pre_reset_count", bus.count, 3);
        bus.ctrl_readRegA = 10;
        ctrl_reset = 1'b1;
        cycle();
        ctrl_reset = 1'b0;
        check("post_reset_count", bus.count, 0);
        check("post_reset_hit", bus.fwd_hitA, 0);
        for (int i = 0; i < 3; i++) cycle();

        // Wrap-around with continuous drain.
        for (int i = 1; i <= 10; i++) begin
            set_a(1, ADDR_W'(i), DATA_W'(i * 256));
            cycle();
            check("wrap_count_le2", bus.count <= 2, 1);
        end
        drain();

        // Random traffic; producers hold their request while it is stalled.
        for (int n = 0; n < 400; n++) begin
            if (!(bus.a_valid && !last_a_acc))
                set_a(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), $urandom);
            if (!(bus.b_valid && !last_b_acc))
                set_b(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), $urandom);
            bus.ctrl_readRegA = ADDR_W'($urandom_range(0, 7));
            bus.ctrl_readRegB = ADDR_W'($urandom_range(0, 7));
            ctrl_reset = ($urandom_range(0, 49) == 0);
            cycle();
        end
        ctrl_reset = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
